// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the boot image source and the loader.
// A byte moves when byte_valid and byte_ready are both high at a rising clock edge.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Receives a framed byte stream: LEN_L, LEN_H, then 4*N payload bytes (LSB first), then CHK.
// CHK is the XOR of all payload bytes.
// Each completed word is written to instruction memory with a single-cycle strobe.
// The CPU is held in reset until a complete, checksum-verified image has been loaded.
module imem_loader #(
  parameter int TAM     = 1024,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t           state;
  state_t           nxt;

  logic [15:0]      len_q;
  logic [7:0]       acc;
  logic [1:0]       byte_idx;
  logic [31:0]      word_sr;
  logic [CNT_W-1:0] idle_cnt;

  logic             xfer;
  logic             active;
  logic             start_sess;
  logic [15:0]      n_req;
  logic             len_bad;
  logic             last_word;
  logic             timeout_hit;

  // Handshake, session and frame-decode qualifiers shared by the FSM and datapath
  always_comb begin
    xfer        = bus.byte_valid & bus.byte_ready;
    active      = (state == ST_LEN0) || (state == ST_LEN1) ||
                  (state == ST_DATA) || (state == ST_CHECK);
    start_sess  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    n_req       = {bus.byte_data, len_q[7:0]};
    len_bad     = (n_req == 16'd0) || ({16'd0, n_req} > 32'(TAM));
    last_word   = (words_loaded + 16'd1) == len_q;
    timeout_hit = active && !xfer && (idle_cnt == CNT_W'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic; an idle timeout overrides everything while a session is active
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (start) nxt = ST_LEN0;
      ST_LEN0:  if (xfer) nxt = ST_LEN1;
      ST_LEN1:  if (xfer) nxt = len_bad ? ST_ERR : ST_DATA;
      ST_DATA:  if (xfer && (byte_idx == 2'd3) && last_word) nxt = ST_CHECK;
      ST_CHECK: if (xfer) nxt = (bus.byte_data == acc) ? ST_DONE : ST_ERR;
      ST_DONE:  if (start) nxt = ST_LEN0;
      ST_ERR:   if (start) nxt = ST_LEN0;
      default:  nxt = ST_IDLE;
    endcase
    if (timeout_hit) nxt = ST_ERR;
  end

  // Status outputs registered from the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.byte_ready <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_hold       <= 1'b1;
    end else begin
      bus.byte_ready <= (nxt == ST_LEN0) || (nxt == ST_LEN1) ||
                        (nxt == ST_DATA) || (nxt == ST_CHECK);
      done           <= (nxt == ST_DONE);
      error          <= (nxt == ST_ERR);
      cpu_hold       <= (nxt != ST_DONE);
    end
  end

  // Idle-cycle counter: cleared by any transfer and whenever no session is active
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (xfer || !active) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Frame datapath: length capture, word assembly, checksum and memory write strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q        <= '0;
      acc          <= '0;
      byte_idx     <= '0;
      word_sr      <= '0;
      words_loaded <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
    end else begin
      im_we <= 1'b0;
      if (start_sess) begin
        words_loaded <= '0;
        acc          <= '0;
        byte_idx     <= '0;
      end
      if (xfer) begin
        unique case (state)
          ST_LEN0: len_q[7:0]  <= bus.byte_data;
          ST_LEN1: len_q[15:8] <= bus.byte_data;
          ST_DATA: begin
            // Shifting in from the top leaves the first byte of each group in lane 0
            word_sr  <= {bus.byte_data, word_sr[31:8]};
            acc      <= acc ^ bus.byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              im_we        <= 1'b1;
              im_addr      <= words_loaded[ADDR_W-1:0];
              im_wdata     <= {bus.byte_data, word_sr[31:8]};
              words_loaded <= words_loaded + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
